pmem_tag_arbiter: RTL and testbench
===================================

# pmem_tag_arbiter

Shares the single match-result port (`tagin`) of the packet-memory group among several match engines. Tags arrive as single-beat valid/ready requests from N_REQ requesters. The block grants one request per cycle in round-robin order and queues it in a 2-entry output buffer. It then presents the tag, with its source index, to the packet-memory group's `tagin` stream. Per-requester grant counters give visibility into fairness.

## Interface
Parameters:
- N_REQ, 4, number of match-engine requesters (2..8)
- TAG_W, 14, tag width; must equal packet-memory group `tagin_data` width
- CNT_W, 16, width of each per-requester grant counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 resets all state
- req_data  in  [TAG_W-1:0] x N_REQ (unpacked array)  tag from requester i
- req_valid  in  1 x N_REQ  requester i has a tag
- req_ready  out  1 x N_REQ  tag from requester i accepted this cycle
- tagin_data  out  TAG_W  tag to packet-memory group
- tagin_src  out  $clog2(N_REQ)  requester index of `tagin_data`
- tagin_valid  out  1  output tag valid
- tagin_ready  in  1  packet-memory group accepts tag
- clear_counts  in  1  synchronous clear of all grant counters
- grant_count  out  [CNT_W-1:0] x N_REQ  saturating count of accepted tags per requester

## Operation
- **Tag payload:** opaque; passed unmodified.
- **Round-robin pointer:** `rr_ptr` (0..N_REQ-1) marks the highest-priority requester.
  - Grant goes to the first i with `req_valid[i]`, scanning rr_ptr, rr_ptr+1, … mod N_REQ.
- **Accept condition:** buffer occupancy `count < 2` and reset deasserted.
  - `req_ready[g]=1` for the granted g only; all other `req_ready` are 0.
  - Ready never depends combinationally on `tagin_ready`.
- **On accept from g:**
  - push {tag, g} into the buffer;
  - `rr_ptr <= (g+1) mod N_REQ`;
  - `grant_count[g]` increments, saturating at 2^CNT_W-1.
- **No accept:** `rr_ptr` holds.
- **Output buffer:** 2-entry FIFO, strict order.
  - `tagin_valid = (count != 0)`; `tagin_data`/`tagin_src` come from the head entry.
  - Pop when `tagin_valid & tagin_ready`.
- **Simultaneous push+pop:** `count` unchanged, order preserved. At count==2 only a pop is possible.
- **Output stability:** while `tagin_valid=1` and `tagin_ready=0`, `tagin_data` and `tagin_src` are held stable.
- **clear_counts:** zeroes all counters next edge. It wins over a same-cycle increment, so that accept is not counted.
- **Reset (including mid-operation):**
  - buffer flushed; in-flight tags discarded;
  - `rr_ptr=0`, counters 0.
  - Requesters hold `req_valid` across reset; tags not accepted are not lost.

## Timing
- **Reset values:** `tagin_valid=0`, `tagin_data=0`, `tagin_src=0`, `req_ready=0` (all), `grant_count=0` (all).
- **Latency:** accept on edge t → `tagin_valid=1` with that tag after edge t (visible in cycle t+1) when the buffer was empty.
- **Throughput:** 1 tag/cycle sustained while `tagin_ready=1`, because count never exceeds 1.
- **Backpressure:** with `tagin_ready=0`, at most 2 accepts occur, then all `req_ready=0` until a pop.
  - After a pop edge, count=1 and an accept is allowed in the following cycle.
- **Fairness:** with all requesters continuously valid and no backpressure, grants cycle 0,1,…,N_REQ-1 exactly.
- **Grant latency bound:** a continuously valid requester is granted within N_REQ accept opportunities.

## Structure
- **Shared package `pmem_pkg`:**
  - constants `PMEM_TAG_W=14`, `PMEM_N_PORTS=4`;
  - `typedef logic [PMEM_TAG_W-1:0] pmem_tag_t`.
- **Sub-module `pmem_rr_arbiter`:**
  - combinational one-hot grant plus encoded index from valid vector and pointer;
  - registered pointer update on accept.
- **Top level:** 2-entry FIFO, counters and handshakes stay in `pmem_tag_arbiter`.

## Test plan
- **Reset:** `reset=0` with all `req_valid=1` → all outputs 0, `req_ready=0`. Release → first grant to requester 0, `tagin_valid=1` one cycle later.
- **Fairness:** all 4 requesters valid with distinct tags (0x0A0+i), `tagin_ready=1` for 12 cycles → `tagin_src` sequence 0,1,2,3 repeated 3 times, each `grant_count=3`.
- **Backpressure:** `tagin_ready=0` with requesters 1 and 3 valid → exactly two accepts (src 1, then 3), then `req_ready` all 0. Raise `tagin_ready` → tags emerge in order and `tagin_data` is stable while stalled.
- **Sparse:** only requester 2 valid every other cycle → every request granted the cycle it is valid, `rr_ptr` cycles to 3. No bubbles beyond 1-cycle latency.
- **Counters:** preload `grant_count[0]` near saturation via CNT_W=4 build, run 20 grants from requester 0 → holds 15. Then `clear_counts` coincident with an accept → 0.
- **Mid-operation reset:** assert reset with count=2 → `tagin_valid=0` immediately (async). After release, the old tags never appear and requesters' held tags are re-accepted.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared packet-memory constants and types used by the tag arbiter slice.
package pmem_pkg;

  localparam int PMEM_TAG_W   = 14;
  localparam int PMEM_N_PORTS = 4;

  typedef logic [PMEM_TAG_W-1:0] pmem_tag_t;

  // Modulo-n increment of an index in 0..n-1.
  function automatic int pmem_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pmem_tag_arbiter_if.sv
// Request side (N_REQ single-beat valid/ready tags) and tagin stream of the tag arbiter.
interface pmem_tag_arbiter_if #(
  parameter int N_REQ = pmem_pkg::PMEM_N_PORTS,
  parameter int TAG_W = pmem_pkg::PMEM_TAG_W
);

  localparam int SRC_W = $clog2(N_REQ);

  logic [TAG_W-1:0] req_data [N_REQ];
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [TAG_W-1:0] tagin_data;
  logic [SRC_W-1:0] tagin_src;
  logic             tagin_valid;
  logic             tagin_ready;

  // master: requesters plus the packet-memory consumer; slave: the arbiter
  modport master (
    output req_data, req_valid, tagin_ready,
    input  req_ready, tagin_data, tagin_src, tagin_valid
  );

  modport slave (
    input  req_data, req_valid, tagin_ready,
    output req_ready, tagin_data, tagin_src, tagin_valid
  );

endinterface

// File: rtl/pmem_rr_arbiter.sv
// Round-robin grant selection: one-hot + encoded grant from the valid vector,
// pointer moves past the winner only when the grant is actually taken.
module pmem_rr_arbiter
  import pmem_pkg::*;
#(
  parameter int N_REQ = PMEM_N_PORTS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           valid,
  input  logic                       accept,
  output logic [N_REQ-1:0]           grant_onehot,
  output logic [$clog2(N_REQ)-1:0]   grant_idx,
  output logic                       grant_any
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;

  // Scan starting at the pointer; the first valid requester found wins.
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] idx;
    pos          = 0;
    idx          = '0;
    grant_onehot = '0;
    grant_idx    = '0;
    grant_any    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(rr_ptr_reg) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      idx = IDX_W'(pos);
      if (!grant_any && valid[idx]) begin
        grant_any         = 1'b1;
        grant_idx         = idx;
        grant_onehot[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (accept) rr_ptr_next = IDX_W'(pmem_wrap_inc(int'(grant_idx), N_REQ));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rr_ptr_reg <= '0;
    else        rr_ptr_reg <= rr_ptr_next;
  end

endmodule

// File: rtl/pmem_tag_arbiter.sv
// Shares the packet-memory tagin port among N_REQ match engines: round-robin
// grant, 2-entry ordered output buffer, saturating per-requester grant counters.
module pmem_tag_arbiter
  import pmem_pkg::*;
#(
  parameter int N_REQ = PMEM_N_PORTS,
  parameter int TAG_W = PMEM_TAG_W,
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  pmem_tag_arbiter_if.slave     bus,
  input  logic                  clear_counts,
  output logic [CNT_W-1:0]      grant_count [N_REQ]
);

  localparam int SRC_W = $clog2(N_REQ);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SRC_W-1:0] src;
  } entry_t;

  entry_t           fifo_mem [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;

  logic [N_REQ-1:0] grant_onehot;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_any;
  logic             can_accept;
  logic             accept;
  logic             pop;

  // Ready looks only at local occupancy, never at tagin_ready.
  assign can_accept    = (count_reg != 2'd2) && reset;
  assign accept        = can_accept && grant_any;
  assign pop           = (count_reg != 2'd0) && bus.tagin_ready;
  assign bus.req_ready = can_accept ? grant_onehot : '0;

  pmem_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .clock        (clock),
    .reset        (reset),
    .valid        (bus.req_valid),
    .accept       (accept),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_any    (grant_any)
  );

  always_comb begin
    count_next = count_reg;
    if (accept && !pop)      count_next = count_reg + 2'd1;
    else if (pop && !accept) count_next = count_reg - 2'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (accept) begin
        fifo_mem[wr_ptr_reg] <= '{tag: bus.req_data[grant_idx], src: grant_idx};
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // Head entry only changes on a pop, so a stalled output stays stable.
  assign bus.tagin_valid = (count_reg != 2'd0);
  assign bus.tagin_data  = fifo_mem[rd_ptr_reg].tag;
  assign bus.tagin_src   = fifo_mem[rd_ptr_reg].src;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    // clear_counts takes priority over a same-cycle grant.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_reg <= '0;
      end else if (clear_counts) begin
        cnt_reg <= '0;
      end else if (accept && grant_onehot[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    assign grant_count[gi] = cnt_reg;
  end

endmodule

// File: tb/tb_pmem_tag_arbiter.sv
// Self-checking bench for pmem_tag_arbiter: queue-based reference model checked
// every cycle, plus directed phases with hand-computed literal expectations.
module tb_pmem_tag_arbiter;
  import pmem_pkg::*;

  localparam int N  = 4;
  localparam int TW = 14;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear_counts = 1'b0;
  logic [CW-1:0] grant_count [N];

  pmem_tag_arbiter_if #(.N_REQ(N), .TAG_W(TW)) bus ();

  pmem_tag_arbiter #(
    .N_REQ (N),
    .TAG_W (TW),
    .CNT_W (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .clear_counts (clear_counts),
    .grant_count  (grant_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Reference model: ordered queue of {tag, src}, priority pointer, counters.
  typedef struct {
    logic [TW-1:0] tag;
    int            src;
  } ent_t;

  ent_t          mq [$];
  int            m_rr;
  int            m_cnt [N];
  int            pop_src_log [$];
  logic [TW-1:0] pop_data_log [$];
  int            acc_log [$];

  always @(negedge clock) begin : cmp
    int         g;
    logic [N-1:0] exp_ready;
    bit         acc;
    g         = -1;
    exp_ready = '0;
    acc       = 1'b0;
    if (!reset) begin
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_tagin_valid", bus.tagin_valid, 0);
      check("rst_tagin_data", bus.tagin_data, 0);
      check("rst_tagin_src", bus.tagin_src, 0);
      for (int i = 0; i < N; i++) check("rst_grant_count", grant_count[i], 0);
      mq.delete();
      m_rr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (g < 0 && bus.req_valid[i]) g = i;
      end
      if (mq.size() < 2 && g >= 0) begin
        exp_ready[g] = 1'b1;
        acc = 1'b1;
      end
      check("req_ready", bus.req_ready, exp_ready);
      check("tagin_valid", bus.tagin_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("tagin_data", bus.tagin_data, mq[0].tag);
        check("tagin_src", bus.tagin_src, mq[0].src);
      end
      for (int i = 0; i < N; i++) check("grant_count", grant_count[i], m_cnt[i]);

      if (bus.tagin_valid && bus.tagin_ready) begin
        pop_src_log.push_back(int'(bus.tagin_src));
        pop_data_log.push_back(bus.tagin_data);
        $display("tag out: src=%0d data=0x%0h", bus.tagin_src, bus.tagin_data);
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc_log.push_back(i);
          $display("tag in : req=%0d data=0x%0h", i, bus.req_data[i]);
        end
      end

      if (mq.size() != 0 && bus.tagin_ready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{bus.req_data[g], g});
        m_rr = (g + 1) % N;
      end
      if (clear_counts) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (acc && m_cnt[g] < CMAX) begin
        m_cnt[g]++;
      end
    end
  end

  task automatic clear_logs();
    pop_src_log.delete();
    pop_data_log.delete();
    acc_log.delete();
  endtask

  initial begin
    bus.req_valid   = '0;
    bus.tagin_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.req_data[i] = TW'(32'h0A0 + i);

    // Reset with every requester valid
    #1 reset = 1'b0;
    bus.req_valid = 4'hF;
    tick(3);
    check("lit_rst_ready", bus.req_ready, 0);
    check("lit_rst_valid", bus.tagin_valid, 0);
    clear_logs();
    reset = 1'b1;
    #1;
    check("lit_first_grant", bus.req_ready, 4'b0001);

    // Fairness: 12 accepts with all four valid
    tick(1);
    check("lit_first_valid", bus.tagin_valid, 1);
    check("lit_first_src", bus.tagin_src, 0);
    check("lit_first_data", bus.tagin_data, 14'h0A0);
    tick(11);
    bus.req_valid = '0;
    tick(2);
    check("lit_fair_pops", pop_src_log.size(), 12);
    for (int k = 0; k < pop_src_log.size() && k < 12; k++)
      check("lit_fair_src_seq", pop_src_log[k], k % N);
    for (int i = 0; i < N; i++) check("lit_fair_count", grant_count[i], 3);

    // Backpressure: requesters 1 and 3, consumer stalled
    clear_logs();
    bus.tagin_ready = 1'b0;
    bus.req_valid   = 4'b1010;
    tick(1);
    check("lit_bp_head_data", bus.tagin_data, 14'h0A1);
    tick(3);
    check("lit_bp_stable_data", bus.tagin_data, 14'h0A1);
    check("lit_bp_stable_src", bus.tagin_src, 1);
    check("lit_bp_ready_zero", bus.req_ready, 0);
    check("lit_bp_accepts", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      check("lit_bp_acc0", acc_log[0], 1);
      check("lit_bp_acc1", acc_log[1], 3);
    end
    bus.req_valid   = '0;
    bus.tagin_ready = 1'b1;
    tick(3);
    check("lit_bp_pops", pop_src_log.size(), 2);
    if (pop_src_log.size() == 2) begin
      check("lit_bp_pop0", pop_src_log[0], 1);
      check("lit_bp_pop1", pop_src_log[1], 3);
    end

    // Sparse: requester 2 every other cycle
    clear_logs();
    repeat (4) begin
      bus.req_valid = 4'b0100;
      tick(1);
      check("lit_sparse_valid", bus.tagin_valid, 1);
      check("lit_sparse_src", bus.tagin_src, 2);
      bus.req_valid = '0;
      tick(1);
    end
    tick(1);
    check("lit_sparse_accepts", acc_log.size(), 4);
    check("lit_sparse_pops", pop_src_log.size(), 4);
    check("lit_sparse_count2", grant_count[2], 7);

    // Counter saturation and clear coincident with an accept
    clear_logs();
    bus.req_valid = 4'b0001;
    tick(20);
    check("lit_sat_count0", grant_count[0], CMAX);
    clear_counts = 1'b1;
    tick(1);
    check("lit_clear_acc_seen", acc_log.size(), 21);
    clear_counts  = 1'b0;
    bus.req_valid = '0;
    #1;
    for (int i = 0; i < N; i++) check("lit_clear_count", grant_count[i], 0);
    tick(2);

    // Mid-operation reset with the buffer full
    bus.tagin_ready = 1'b0;
    bus.req_valid   = 4'b0110;
    tick(3);
    check("lit_mr_full_ready", bus.req_ready, 0);
    check("lit_mr_full_valid", bus.tagin_valid, 1);
    reset = 1'b0;
    #1;
    check("lit_mr_async_valid", bus.tagin_valid, 0);
    bus.req_data[1] = 14'h1B1;
    bus.req_data[2] = 14'h1B2;
    tick(2);
    clear_logs();
    reset           = 1'b1;
    bus.tagin_ready = 1'b1;
    tick(2);
    bus.req_valid = '0;
    tick(3);
    check("lit_mr_pops", pop_src_log.size(), 2);
    if (pop_src_log.size() == 2) begin
      check("lit_mr_src0", pop_src_log[0], 1);
      check("lit_mr_src1", pop_src_log[1], 2);
      check("lit_mr_data0", pop_data_log[0], 14'h1B1);
      check("lit_mr_data1", pop_data_log[1], 14'h1B2);
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
